blft_win_seq: RTL and testbench

BLFT_WIN_SEQ -- requirements
Module: blft_win_seq

---
 rtl/blft_win_seq.sv | 157 +++++++++++++++
 tb/tb_blft_win_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blft_win_seq.sv
// Window-fetch sequencer for a (2*RAD+1)x(2*RAD+1) sliding-window image filter.
// Walks every interior centre pixel of a square IMG_DIM x IMG_DIM frame.
// The window is streamed in column-major order from image memory.
// At the start of each centre row it primes 2*RAD columns.
// For each centre it then fetches one new column and waits for the datapath
// to acknowledge the assembled window.
// Image addresses are {row[7:0], col[7:0]}.
module blft_win_seq #(
    parameter int RAD     = 5,
    parameter int IMG_DIM = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic [15:0] in_addr,
    output logic        fetch_en,
    output logic        win_wr,
    output logic [3:0]  win_idx,
    output logic        col_shift,
    output logic        win_ready,
    input  logic        win_ack,
    output logic [15:0] ctr_addr,
    output logic        busy,
    output logic        done
);

    // First and last centre coordinate, last image column, last primed column
    localparam logic [7:0] RAD_V     = 8'(RAD);
    localparam logic [7:0] LAST_CTR  = 8'(IMG_DIM - 1 - RAD);
    localparam logic [7:0] LAST_COL  = 8'(IMG_DIM - 1);
    localparam logic [7:0] PRIME_END = 8'(2 * RAD - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        FETCH,
        WAIT,
        DONE
    } state_t;

    state_t     state, state_n;
    logic [7:0] ctr_row, ctr_row_n;
    logic [7:0] ctr_col, ctr_col_n;
    logic [7:0] f_row, f_row_n;
    logic [7:0] f_col, f_col_n;

    // Window extent for the current centre row
    logic [7:0] win_top;
    logic [7:0] win_bot;
    logic       col_end;
    logic       fetching;

    // Window bounds and the "last word of this column" flag
    always_comb begin
        win_top  = ctr_row - RAD_V;
        win_bot  = ctr_row + RAD_V;
        col_end  = (f_row == win_bot);
        fetching = (state == PRIME) || (state == FETCH);
    end

    // State and counter registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ctr_row <= '0;
            ctr_col <= '0;
            f_row   <= '0;
            f_col   <= '0;
        end else begin
            state   <= state_n;
            ctr_row <= ctr_row_n;
            ctr_col <= ctr_col_n;
            f_row   <= f_row_n;
            f_col   <= f_col_n;
        end
    end

    // Next-state and counter update; fetch counters move only on accepted words
    always_comb begin
        state_n   = state;
        ctr_row_n = ctr_row;
        ctr_col_n = ctr_col;
        f_row_n   = f_row;
        f_col_n   = f_col;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    ctr_row_n = RAD_V;
                    ctr_col_n = RAD_V;
                    f_row_n   = '0;
                    f_col_n   = '0;
                    state_n   = PRIME;
                end
            end

            PRIME, FETCH: begin
                if (in_valid) begin
                    if (col_end) begin
                        f_row_n = win_top;
                        // The final column of a row is the last image column;
                        // hold there instead of wrapping to column 0.
                        if (f_col != LAST_COL) begin
                            f_col_n = f_col + 8'd1;
                        end
                        if (state == FETCH) begin
                            state_n = WAIT;
                        end else if (f_col == PRIME_END) begin
                            state_n = FETCH;
                        end
                    end else begin
                        f_row_n = f_row + 8'd1;
                    end
                end
            end

            WAIT: begin
                if (win_ack) begin
                    if (ctr_col != LAST_CTR) begin
                        ctr_col_n = ctr_col + 8'd1;
                        state_n   = FETCH;
                    end else if (ctr_row != LAST_CTR) begin
                        ctr_row_n = ctr_row + 8'd1;
                        ctr_col_n = RAD_V;
                        f_row_n   = ctr_row + 8'd1 - RAD_V;
                        f_col_n   = '0;
                        state_n   = PRIME;
                    end else begin
                        state_n = DONE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Datapath strobes and status decoded from state and fetch position
    always_comb begin
        in_addr   = {f_row, f_col};
        ctr_addr  = {ctr_row, ctr_col};
        fetch_en  = fetching;
        win_wr    = fetching && in_valid;
        col_shift = fetching && in_valid && col_end;
        // Row offset is only meaningful while fetching; forced to 0 otherwise
        // so idle/reset show a clean zero rather than a stale offset.
        win_idx   = '0;
        if (fetching) begin
            win_idx = 4'(f_row - win_top);
        end
        win_ready = (state == WAIT);
        busy      = fetching || (state == WAIT);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_blft_win_seq.sv
// Scoreboard bench for blft_win_seq.
// Instance a: default 256x256 / radius 5.
// Instance b: a 13x13 frame with radius 5, small enough to run to completion.
module tb_blft_win_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_start, a_in_valid, a_win_ack;
    logic [15:0] a_in_addr, a_ctr_addr;
    logic        a_fetch_en, a_win_wr, a_col_shift, a_win_ready, a_busy, a_done;
    logic [3:0]  a_win_idx;

    logic        b_start, b_in_valid, b_win_ack;
    logic [15:0] b_in_addr, b_ctr_addr;
    logic        b_fetch_en, b_win_wr, b_col_shift, b_win_ready, b_busy, b_done;
    logic [3:0]  b_win_idx;

    blft_win_seq u_a (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid),
        .in_addr(a_in_addr), .fetch_en(a_fetch_en), .win_wr(a_win_wr),
        .win_idx(a_win_idx), .col_shift(a_col_shift), .win_ready(a_win_ready),
        .win_ack(a_win_ack), .ctr_addr(a_ctr_addr), .busy(a_busy), .done(a_done)
    );

    blft_win_seq #(.RAD(5), .IMG_DIM(13)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid),
        .in_addr(b_in_addr), .fetch_en(b_fetch_en), .win_wr(b_win_wr),
        .win_idx(b_win_idx), .col_shift(b_col_shift), .win_ready(b_win_ready),
        .win_ack(b_win_ack), .ctr_addr(b_ctr_addr), .busy(b_busy), .done(b_done)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  idx;
        logic        shift;
    } word_t;

    word_t       a_words[$];
    logic [15:0] a_wins[$];
    logic [15:0] b_wins[$];

    logic [41:0] a_outs;
    assign a_outs = {a_in_addr, a_ctr_addr, a_fetch_en, a_win_wr, a_win_idx,
                     a_col_shift, a_win_ready, a_busy, a_done};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One window column: rows crow-5..crow+5 of column col
    task automatic push_col(input int col, input int crow);
        word_t w;
        for (int r = crow - 5; r <= crow + 5; r++) begin
            w.addr  = {8'(r), 8'(col)};
            w.idx   = 4'(r - (crow - 5));
            w.shift = (r == crow + 5);
            a_words.push_back(w);
        end
    endtask

    task automatic push_prime(input int crow);
        for (int c = 0; c < 10; c++) push_col(c, crow);
    endtask

    word_t       a_exp_w;
    logic [15:0] a_exp_c;
    logic [15:0] b_exp_c;

    // Monitor for instance a: every captured word and every accepted window
    always @(negedge clk) begin
        if (a_win_wr) begin
            if (a_words.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_word_unexpected: got addr 0x%0h, expected no capture at %0t", a_in_addr, $time);
            end else begin
                a_exp_w = a_words.pop_front();
                check("a_word", 64'({a_in_addr, a_win_idx, a_col_shift}), 64'(a_exp_w));
            end
        end
        if (a_win_ready && a_win_ack) begin
            if (a_wins.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_win_unexpected: got ctr 0x%0h, expected no window at %0t", a_ctr_addr, $time);
            end else begin
                a_exp_c = a_wins.pop_front();
                check("a_window", 64'(a_ctr_addr), 64'(a_exp_c));
            end
        end
    end

    // Monitor for instance b: accepted windows only
    always @(negedge clk) begin
        if (b_win_ready && b_win_ack) begin
            if (b_wins.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_win_unexpected: got ctr 0x%0h, expected no window at %0t", b_ctr_addr, $time);
            end else begin
                b_exp_c = b_wins.pop_front();
                check("b_window", 64'(b_ctr_addr), 64'(b_exp_c));
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  hs;
        logic seen;

        rst = 1'b1;
        a_start = 1'b0; a_in_valid = 1'b0; a_win_ack = 1'b0;
        b_start = 1'b0; b_in_valid = 1'b0; b_win_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("a_reset_outputs", 64'(a_outs), 64'd0);

        // Input activity without start changes nothing
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1'(i % 2);
            a_win_ack  = 1'(i / 3);
            @(posedge clk); #1;
        end
        check("a_idle_no_start", 64'(a_outs), 64'd0);
        a_win_ack = 1'b0;

        // Abort a frame mid-PRIME with reset
        push_prime(5);
        a_in_valid = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        check("a_prime_start_addr", 64'(a_in_addr), 64'h0000);
        repeat (30) @(posedge clk);
        #1;
        check("a_mid_prime_busy", 64'(a_busy), 64'd1);
        rst = 1'b1;
        #1;
        check("a_async_reset", 64'(a_outs), 64'd0);
        @(posedge clk); #1;
        check("a_reset_next_edge", 64'(a_outs), 64'd0);
        a_words.delete();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("a_after_reset_idle", 64'(a_outs), 64'd0);

        // Full first centre row plus first window of the second row
        push_prime(5);
        push_col(10, 5);
        a_wins.push_back(16'h0505);
        for (int c = 6; c <= 250; c++) begin
            push_col(c + 5, 5);
            a_wins.push_back({8'h05, 8'(c)});
        end
        push_prime(6);
        push_col(10, 6);
        a_wins.push_back(16'h0605);

        a_in_valid = 1'b1;
        a_win_ack  = 1'b0;
        a_start    = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        n = 0;
        while (!a_win_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_first_ready_latency", 64'(n), 64'd121);
        check("a_first_ctr", 64'(a_ctr_addr), 64'h0505);

        // Hold the acknowledge low: window and fetch pointer stay frozen
        for (int i = 0; i < 5; i++) begin
            check("a_stall_ready", 64'(a_win_ready), 64'd1);
            check("a_stall_ctr", 64'(a_ctr_addr), 64'h0505);
            check("a_stall_addr", 64'(a_in_addr), 64'h000B);
            check("a_stall_wr", 64'(a_win_wr), 64'd0);
            @(posedge clk); #1;
        end
        a_win_ack = 1'b1;
        @(posedge clk); #1;
        check("a_post_ack_fetch", 64'(a_fetch_en), 64'd1);
        check("a_post_ack_ready", 64'(a_win_ready), 64'd0);
        check("a_post_ack_ctr", 64'(a_ctr_addr), 64'h0506);
        check("a_post_ack_addr", 64'(a_in_addr), 64'h000B);

        // Random memory stalls through to the row wrap
        seen = 1'b0;
        for (int k = 0; k < 40000 && !seen; k++) begin
            a_in_valid = 1'($urandom_range(0, 1));
            if (a_win_ready && a_ctr_addr == 16'h05FA) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("a_row_wrap_reached", 64'(seen), 64'd1);
        check("a_wrap_addr", 64'(a_in_addr), 64'h0100);
        check("a_wrap_prime", 64'({a_fetch_en, a_busy, a_win_ready}), 64'b110);
        check("a_wrap_ctr", 64'(a_ctr_addr), 64'h0605);

        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            a_in_valid = 1'($urandom_range(0, 1));
            if (a_win_ready) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("a_second_row_ready", 64'(seen), 64'd1);
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        a_win_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("a_words_left", 64'(a_words.size()), 64'd0);
        check("a_wins_left", 64'(a_wins.size()), 64'd0);

        // Whole small frame on instance b, then a restart
        for (int r = 5; r <= 7; r++)
            for (int c = 5; c <= 7; c++)
                b_wins.push_back({8'(r), 8'(c)});
        b_in_valid = 1'b1;
        b_win_ack  = 1'b1;
        b_start    = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        hs = 0;
        n  = 0;
        while (!b_done && n < 3000) begin
            if (b_win_ready && b_win_ack) hs++;
            @(posedge clk); #1;
            n++;
        end
        check("b_done", 64'(b_done), 64'd1);
        check("b_done_busy", 64'(b_busy), 64'd0);
        check("b_window_count", 64'(hs), 64'd9);
        check("b_wins_left", 64'(b_wins.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("b_done_held", 64'({b_done, b_busy, b_fetch_en}), 64'b100);
        b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        check("b_restart_status", 64'({b_done, b_busy, b_fetch_en}), 64'b011);
        check("b_restart_addr", 64'(b_in_addr), 64'h0000);
        check("b_restart_ctr", 64'(b_ctr_addr), 64'h0505);
        b_in_valid = 1'b0;
        b_win_ack  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
